branch_metric_param: RTL and testbench

Parametrised branch metric unit for the Viterbi decoder. It takes the generator polynomials at run time and builds an internal codeword table with a sequencer, one entry per cycle. It then streams received symbols through a valid/ready handshake and returns the branch metric of every (state, input bit) branch one cycle later. It sits between the input slicer and the add-compare-select array. Hard- or soft-decision metrics are selected at compile time.

---
 rtl/branch_metric_param.sv | 139 +++++++++++++
 tb/tb_branch_metric_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_metric_param.sv
// Viterbi branch metric unit: builds a codeword table from run-time generator polynomials,
// then streams symbols into registered per-branch metrics. Define SOFT_DECISION_EN for soft metrics.
module branch_metric_param #(
  parameter int K = 3,
  parameter int N = 2,
  parameter int Q = 3,
  localparam int BRANCHES = 2 ** K,
  localparam int QMAX = 2 ** Q - 1,
`ifdef SOFT_DECISION_EN
  localparam int MW = $clog2(N * QMAX + 1)
`else
  localparam int MW = $clog2(N + 1)
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cfg_valid,
  input  logic [N*K-1:0]         i_poly,
  output logic                   o_busy,
  input  logic                   i_rx_valid,
  input  logic [N*Q-1:0]         i_rx,
  output logic                   o_rx_ready,
  output logic                   o_valid,
  input  logic                   i_out_ready,
  output logic [BRANCHES*MW-1:0] o_dist
);

  typedef enum logic [1:0] {IDLE, BUILD, RUN} state_t;

  state_t                 state_q, state_d;
  logic [N*K-1:0]         poly_q, poly_d;
  logic [K-1:0]           idx_q, idx_d;
  logic [BRANCHES*N-1:0]  table_q;
  logic                   valid_q, valid_d;
  logic [BRANCHES*MW-1:0] dist_q, dist_d;
  logic                   tbl_we;
  logic                   dist_ld;
  logic                   rx_ready;
  logic [K-1:0]           shift_r;
  logic [N-1:0]           cw_build;

  // Branch b = 2*s+u, so the shift register {u, s} is the index rotated right by one.
  assign shift_r = {idx_q[0], idx_q[K-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cw
      assign cw_build[gi] = ^(poly_q[gi*K +: K] & shift_r);
    end
  endgenerate

  generate
    for (gi = 0; gi < BRANCHES; gi++) begin : g_metric
      logic [MW-1:0] acc;
      always_comb begin
        acc = '0;
        for (int j = 0; j < N; j++) begin
`ifdef SOFT_DECISION_EN
          // Inverting the field when the expected bit is 1 yields QMAX - field.
          acc = acc + MW'(i_rx[j*Q +: Q] ^ {Q{table_q[gi*N + j]}});
`else
          acc = acc + MW'(i_rx[j*Q + Q - 1] ^ table_q[gi*N + j]);
`endif
        end
      end
      assign dist_d[gi*MW +: MW] = acc;
    end
  endgenerate

`ifndef SOFT_DECISION_EN
  logic rx_lsb_unused;
  assign rx_lsb_unused = ^i_rx;
`endif

  always_comb begin
    state_d  = state_q;
    poly_d   = poly_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    tbl_we   = 1'b0;
    dist_ld  = 1'b0;
    rx_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cfg_valid) begin
          poly_d  = i_poly;
          idx_d   = '0;
          state_d = BUILD;
        end
      end
      BUILD: begin
        tbl_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == K'(BRANCHES - 1)) state_d = RUN;
      end
      RUN: begin
        if (i_cfg_valid) begin
          valid_d = 1'b0;
          poly_d  = i_poly;
          idx_d   = '0;
          state_d = BUILD;
        end else begin
          rx_ready = !valid_q || i_out_ready;
          if (rx_ready && i_rx_valid) begin
            valid_d = 1'b1;
            dist_ld = 1'b1;
          end else if (i_out_ready) begin
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      poly_q  <= '0;
      idx_q   <= '0;
      table_q <= '0;
      valid_q <= 1'b0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      if (tbl_we) table_q[idx_q*N +: N] <= cw_build;
      if (dist_ld) dist_q <= dist_d;
    end
  end

  assign o_busy     = (state_q == BUILD);
  assign o_rx_ready = rx_ready;
  assign o_valid    = valid_q;
  assign o_dist     = dist_q;

endmodule

// File: tb/tb_branch_metric_param.sv
// Directed bench for branch_metric_param (K=3, N=2, Q=3); follows SOFT_DECISION_EN if defined.
module tb_branch_metric_param;
  localparam int K  = 3;
  localparam int N  = 2;
  localparam int Q  = 3;
  localparam int BR = 8;
`ifdef SOFT_DECISION_EN
  localparam int MW = 4;
  localparam int SC = 7;
`else
  localparam int MW = 2;
  localparam int SC = 1;
`endif

  logic          clk;
  logic          rst;
  logic          i_cfg_valid;
  logic [N*K-1:0] i_poly;
  logic          o_busy;
  logic          i_rx_valid;
  logic [N*Q-1:0] i_rx;
  logic          o_rx_ready;
  logic          o_valid;
  logic          i_out_ready;
  logic [BR*MW-1:0] o_dist;

  int n_tests = 0;
  int n_fail  = 0;

  branch_metric_param #(.K(K), .N(N), .Q(Q)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cfg_valid(i_cfg_valid),
    .i_poly     (i_poly),
    .o_busy     (o_busy),
    .i_rx_valid (i_rx_valid),
    .i_rx       (i_rx),
    .o_rx_ready (o_rx_ready),
    .o_valid    (o_valid),
    .i_out_ready(i_out_ready),
    .o_dist     (o_dist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] %s ok (%0h)", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // d holds one hex digit per branch, b7 in the top digit down to b0 in the bottom digit.
  function automatic logic [63:0] pack(input logic [31:0] d, input int sc);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < BR; b++) v = v | ((64'(d[4*b +: 4]) * 64'(sc)) << (b * MW));
    return v;
  endfunction

  task automatic wait_build(input string tag);
    int cnt;
    int guard;
    logic ready_seen;
    cnt = 0;
    guard = 0;
    ready_seen = 1'b0;
    while (o_busy && guard < 32) begin
      if (o_rx_ready) ready_seen = 1'b1;
      cnt++;
      guard++;
      tick();
    end
    check({tag, "_len"}, 64'(cnt), 64'd8);
    check({tag, "_ready_during"}, 64'(ready_seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    i_cfg_valid = 1'b0;
    i_poly = '0;
    i_rx_valid = 1'b0;
    i_rx = '0;
    i_out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ready", 64'(o_rx_ready), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_dist", 64'(o_dist), 64'd0);

    // Idle must not accept symbols before a configuration
    rst = 1'b1;
    i_rx_valid = 1'b1;
    i_rx = 6'h3f;
    i_out_ready = 1'b1;
    tick();
    tick();
    check("idle_ready", 64'(o_rx_ready), 64'd0);
    check("idle_valid", 64'(o_valid), 64'd0);
    i_rx_valid = 1'b0;

    i_poly = {3'b101, 3'b111};
    i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    check("cfg_busy_first", 64'(o_busy), 64'd1);
    wait_build("build1");
    check("run_ready", 64'(o_rx_ready), 64'd1);
    check("run_valid0", 64'(o_valid), 64'd0);
    check("run_dist0", 64'(o_dist), 64'd0);

`ifdef SOFT_DECISION_EN
    i_rx = {3'd7, 3'd7};
`else
    i_rx = {3'b100, 3'b100};
`endif
    i_rx_valid = 1'b1;
    tick();
    check("sym1_valid", 64'(o_valid), 64'd1);
    check("sym1_dist", 64'(o_dist), pack(32'h1111_2002, SC));
    i_rx = {3'd3, 3'd4};
    tick();
`ifdef SOFT_DECISION_EN
    check("sym2_dist", 64'(o_dist), pack(32'h6886_7777, 1));
`else
    check("sym2_dist", 64'(o_dist), pack(32'h0220_1111, 1));
`endif
    check("sym2_valid", 64'(o_valid), 64'd1);
    i_rx_valid = 1'b0;
    tick();
    check("drain_valid", 64'(o_valid), 64'd0);
`ifdef SOFT_DECISION_EN
    check("drain_hold", 64'(o_dist), pack(32'h6886_7777, 1));
`else
    check("drain_hold", 64'(o_dist), pack(32'h0220_1111, 1));
`endif

    // Backpressure: A held, B waits, release yields B then C
    i_out_ready = 1'b0;
    i_rx = {3'b000, 3'b000};
    i_rx_valid = 1'b1;
    #1;
    check("bp_ready_empty", 64'(o_rx_ready), 64'd1);
    tick();
    i_rx = {3'b000, 3'b111};
    #1;
    check("bp_ready_full", 64'(o_rx_ready), 64'd0);
    check("bp_dist_a", 64'(o_dist), pack(32'h1111_0220, SC));
    tick();
    check("bp_dist_hold", 64'(o_dist), pack(32'h1111_0220, SC));
    check("bp_valid_hold", 64'(o_valid), 64'd1);
    i_out_ready = 1'b1;
    #1;
    check("bp_ready_release", 64'(o_rx_ready), 64'd1);
    tick();
    check("bp_dist_b", 64'(o_dist), pack(32'h0220_1111, SC));
    check("bp_valid_b", 64'(o_valid), 64'd1);
    i_rx = {3'b111, 3'b000};
    tick();
    check("bp_dist_c", 64'(o_dist), pack(32'h2002_1111, SC));
    i_rx_valid = 1'b0;
    tick();
    check("bp_valid_end", 64'(o_valid), 64'd0);

    // Reconfigure while an output is pending
    i_out_ready = 1'b0;
    i_rx = {3'b111, 3'b111};
    i_rx_valid = 1'b1;
    tick();
    check("rc_pending", 64'(o_valid), 64'd1);
    i_cfg_valid = 1'b1;
    i_poly = {3'b011, 3'b110};
    i_rx = {3'b000, 3'b000};
    i_out_ready = 1'b1;
    #1;
    check("rc_ready_blocked", 64'(o_rx_ready), 64'd0);
    tick();
    i_cfg_valid = 1'b0;
    i_rx_valid = 1'b0;
    check("rc_valid_drop", 64'(o_valid), 64'd0);
    check("rc_dist_kept", 64'(o_dist), pack(32'h1111_2002, SC));
    wait_build("build2");
    i_rx = {3'b111, 3'b111};
    i_rx_valid = 1'b1;
    tick();
    check("rc_dist_11", 64'(o_dist), pack(32'h2110_0112, SC));
    i_rx = {3'b111, 3'b000};
    tick();
    check("rc_dist_10", 64'(o_dist), pack(32'h1201_1021, SC));
    i_rx_valid = 1'b0;
    tick();

    // Asynchronous reset in the fourth build cycle
    i_poly = {3'b101, 3'b111};
    i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy_before", 64'(o_busy), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_busy", 64'(o_busy), 64'd0);
    check("mid_ready", 64'(o_rx_ready), 64'd0);
    check("mid_dist", 64'(o_dist), 64'd0);
    #2;
    rst = 1'b1;
    i_rx_valid = 1'b1;
    i_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_ready", 64'(o_rx_ready), 64'd0);
      check("post_rst_busy", 64'(o_busy), 64'd0);
      check("post_rst_valid", 64'(o_valid), 64'd0);
    end
    i_rx_valid = 1'b0;
    i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
    wait_build("build3");
    i_rx = {3'b000, 3'b111};
    i_rx_valid = 1'b1;
    tick();
    check("rebuilt_dist", 64'(o_dist), pack(32'h0220_1111, SC));
    check("rebuilt_valid", 64'(o_valid), 64'd1);
    i_rx_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
